// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-block command initiator:
// opcodes, header/status layout and FSM state encoding.
package reg_cmd_pkg;

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;

  localparam int OP_LSB   = 28;
  localparam int CNT_LSB  = 16;
  localparam int BAD_BIT  = 1;
  localparam int ILL_BIT  = 0;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_DEC   = 4'd1;
  localparam logic [3:0] S_SEL   = 4'd2;
  localparam logic [3:0] S_CHK   = 4'd3;
  localparam logic [3:0] S_WDAT  = 4'd4;
  localparam logic [3:0] S_WSTB  = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_RCAP  = 4'd7;
  localparam logic [3:0] S_RHOLD = 4'd8;
  localparam logic [3:0] S_NEXT  = 4'd9;
  localparam logic [3:0] S_STAT  = 4'd10;

  function automatic logic [31:0] status_word(
    input logic [3:0]  op,
    input logic [11:0] done,
    input logic        bad,
    input logic        ill
  );
    return {op, done, 14'b0, bad, ill};
  endfunction

endpackage

// File: rtl/reg_cmd_initiator.sv
// Decodes link command words into register-block read/write bursts
// and returns read data plus a status trailer on the response stream.
module reg_cmd_initiator
  import reg_cmd_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rx_data,
  output logic        reg_num_le,
  output logic        wr_en,
  output logic        rd_en,
  input  logic [31:0] tx_data,
  input  logic        illegal_reg_num
);

  logic [3:0]        state;
  logic [3:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  done_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ill_q;
  logic              ill_seen;
  logic              bad_op;

  logic [CNT_W-1:0]  done_inc;
  logic [ADDR_W-1:0] addr_inc;
  logic              is_bad;

  assign done_inc = done_q + CNT_W'(1);
  assign addr_inc = addr_q + ADDR_W'(1);
  assign is_bad   = (op_q != OP_WRITE) && (op_q != OP_READ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      addr_q     <= '0;
      ill_q      <= 1'b0;
      ill_seen   <= 1'b0;
      bad_op     <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
      rx_data    <= '0;
      reg_num_le <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
    end else begin
      reg_num_le <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_data[OP_LSB +: 4];
            cnt_q     <= cmd_data[CNT_LSB +: CNT_W];
            addr_q    <= cmd_data[ADDR_W-1:0];
            done_q    <= '0;
            ill_q     <= 1'b0;
            ill_seen  <= 1'b0;
            bad_op    <= 1'b0;
            state     <= S_DEC;
          end
        end
        S_DEC: begin
          if (is_bad) begin
            bad_op    <= 1'b1;
            rsp_data  <= status_word(op_q, 12'(done_q),
                                     1'b1, 1'b0);
            rsp_valid <= 1'b1;
            state     <= S_STAT;
          end else if (cnt_q == '0) begin
            rsp_data  <= status_word(op_q, 12'(done_q),
                                     1'b0, 1'b0);
            rsp_valid <= 1'b1;
            state     <= S_STAT;
          end else begin
            rx_data    <= 32'(addr_q);
            reg_num_le <= 1'b1;
            state      <= S_SEL;
          end
        end
        S_SEL: state <= S_CHK;
        // The flag reflects the register latched in SEL.
        S_CHK: begin
          ill_q <= illegal_reg_num;
          if (op_q == OP_WRITE) begin
            cmd_ready <= 1'b1;
            state     <= S_WDAT;
          end else begin
            rd_en <= !illegal_reg_num;
            state <= S_RD;
          end
        end
        S_WDAT: begin
          if (cmd_valid && cmd_ready) begin
            rx_data   <= cmd_data;
            cmd_ready <= 1'b0;
            wr_en     <= !ill_q;
            ill_seen  <= ill_seen | ill_q;
            state     <= S_WSTB;
          end
        end
        S_WSTB: state <= S_NEXT;
        S_RD:   state <= S_RCAP;
        S_RCAP: begin
          rsp_data  <= ill_q ? '0 : tx_data;
          rsp_valid <= 1'b1;
          ill_seen  <= ill_seen | ill_q;
          state     <= S_RHOLD;
        end
        S_RHOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          addr_q <= addr_inc;
          done_q <= done_inc;
          if (done_inc == cnt_q) begin
            rsp_data  <= status_word(op_q, 12'(done_inc),
                                     bad_op, ill_seen);
            rsp_valid <= 1'b1;
            state     <= S_STAT;
          end else begin
            rx_data    <= 32'(addr_inc);
            reg_num_le <= 1'b1;
            state      <= S_SEL;
          end
        end
        S_STAT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_initiator.sv
// Directed bench for reg_cmd_initiator with a small register-block
// model; transactions come from a vector table plus reset/stall cases.
module tb_reg_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rx_data;
  logic        reg_num_le;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] tx_data;
  logic        illegal_reg_num;

  always #4 clk = ~clk;

  reg_cmd_initiator dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .rsp_data        (rsp_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rx_data         (rx_data),
    .reg_num_le      (reg_num_le),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .tx_data         (tx_data),
    .illegal_reg_num (illegal_reg_num)
  );

  // Register block model: only 0x0020 does not exist.
  logic        mdl_clr;
  logic [15:0] sel_r;
  logic [31:0] wmem [256];
  logic        wvalid [256];

  function automatic logic [31:0] preset(input logic [7:0] a);
    case (a)
      8'h0E:   return 32'h0000_000A;
      8'h0F:   return 32'h0000_000B;
      8'h10:   return 32'h0000_000C;
      8'h1F:   return 32'hCAFE_001F;
      8'h30:   return 32'h1111_2222;
      8'h31:   return 32'h3333_4444;
      default: return 32'h5A00_0000 | 32'(a);
    endcase
  endfunction

  assign illegal_reg_num = (sel_r == 16'h0020);

  always @(posedge clk) begin
    if (mdl_clr) begin
      sel_r   <= '0;
      tx_data <= '0;
      for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
    end else begin
      if (reg_num_le) sel_r <= rx_data[15:0];
      if (wr_en) begin
        wmem[sel_r[7:0]]   <= rx_data;
        wvalid[sel_r[7:0]] <= 1'b1;
      end
      if (rd_en)
        tx_data <= wvalid[sel_r[7:0]] ? wmem[sel_r[7:0]]
                                      : preset(sel_r[7:0]);
    end
  end

  // Strobe monitor
  logic [15:0] sel_q [$];
  logic [15:0] wsel_q [$];
  logic [31:0] wdat_q [$];
  int          rd_cnt  = 0;
  int          overlap = 0;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (reg_num_le) sel_q.push_back(rx_data[15:0]);
      if (wr_en) begin
        wsel_q.push_back(sel_r);
        wdat_q.push_back(rx_data);
      end
      if (rd_en) rd_cnt++;
      if ((wr_en && rd_en) || (reg_num_le && (wr_en || rd_en)))
        overlap++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]       hdr;
    logic [2:0][31:0]  wd;
    int                nwd;
    logic [3:0][31:0]  rsp;
    int                nrsp;
    logic [2:0][15:0]  sel;
    int                nsel;
    logic [1:0][15:0]  wsel;
    logic [1:0][31:0]  wdat;
    int                nwr;
    int                nrd;
    int                stall;
  } vec_t;

  vec_t vecs [9];

  task automatic run_txn(input int id, input vec_t v);
    logic [31:0] words [4];
    logic [31:0] got [4];
    logic [31:0] held;
    int nw, wi, ri, cyc, stall_left, unstable, sb, wb, rb;
    words[0] = v.hdr;
    for (int i = 0; i < 3; i++) words[i+1] = v.wd[i];
    for (int i = 0; i < 4; i++) got[i] = '0;
    nw = 1 + v.nwd;
    wi = 0; ri = 0; cyc = 0; unstable = 0; held = '0;
    stall_left = v.stall;
    sb = sel_q.size(); wb = wdat_q.size(); rb = rd_cnt;
    while ((wi < nw || ri < v.nrsp) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      cmd_valid = (wi < nw);
      cmd_data  = (wi < nw) ? words[wi] : '0;
      if (rsp_valid && stall_left > 0) begin
        if (stall_left == v.stall) held = rsp_data;
        else if (rsp_data !== held) unstable++;
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = 1'b1;
        if (rsp_valid && ri < 4) begin
          got[ri] = rsp_data;
          ri++;
        end
      end
      if (cmd_valid && cmd_ready) wi++;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_finished", id), 32'(cyc < 400), 32'd1);
    chk($sformatf("v%0d_idle", id), 32'(cmd_ready), 32'd1);
    chk($sformatf("v%0d_nrsp", id), ri, v.nrsp);
    for (int i = 0; i < v.nrsp; i++)
      chk($sformatf("v%0d_rsp%0d", id, i), got[i], v.rsp[i]);
    chk($sformatf("v%0d_nsel", id), sel_q.size() - sb, v.nsel);
    for (int i = 0; i < v.nsel && sb + i < sel_q.size(); i++)
      chk($sformatf("v%0d_sel%0d", id, i), 32'(sel_q[sb+i]),
          32'(v.sel[i]));
    chk($sformatf("v%0d_nwr", id), wdat_q.size() - wb, v.nwr);
    for (int i = 0; i < v.nwr && wb + i < wdat_q.size(); i++) begin
      chk($sformatf("v%0d_wsel%0d", id, i), 32'(wsel_q[wb+i]),
          32'(v.wsel[i]));
      chk($sformatf("v%0d_wdat%0d", id, i), wdat_q[wb+i], v.wdat[i]);
    end
    chk($sformatf("v%0d_nrd", id), rd_cnt - rb, v.nrd);
    if (v.stall > 0) begin
      chk($sformatf("v%0d_stall_len", id), stall_left, 0);
      chk($sformatf("v%0d_stall_stable", id), unstable, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_strobes"}, 32'({reg_num_le, wr_en, rd_en}), 32'd0);
    chk({tag, "_rx_data"}, rx_data, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    reset_n   = 1'b0;
    mdl_clr   = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    v = '0; v.hdr = 32'h1001_0002; v.wd[0] = 32'h0000_0123; v.nwd = 1;
    v.rsp[0] = 32'h1001_0000; v.nrsp = 1;
    v.sel[0] = 16'h0002; v.nsel = 1;
    v.wsel[0] = 16'h0002; v.wdat[0] = 32'h0000_0123; v.nwr = 1;
    vecs[0] = v;

    v = '0; v.hdr = 32'h2003_000E;
    v.rsp[0] = 32'hA; v.rsp[1] = 32'hB; v.rsp[2] = 32'hC;
    v.rsp[3] = 32'h2003_0000; v.nrsp = 4;
    v.sel[0] = 16'h000E; v.sel[1] = 16'h000F; v.sel[2] = 16'h0010;
    v.nsel = 3; v.nrd = 3;
    vecs[1] = v;

    v = '0; v.hdr = 32'h2002_001F;
    v.rsp[0] = 32'hCAFE_001F; v.rsp[1] = 32'h0;
    v.rsp[2] = 32'h2002_0001; v.nrsp = 3;
    v.sel[0] = 16'h001F; v.sel[1] = 16'h0020; v.nsel = 2; v.nrd = 1;
    vecs[2] = v;

    v = '0; v.hdr = 32'h7000_0005;
    v.rsp[0] = 32'h7000_0002; v.nrsp = 1;
    vecs[3] = v;

    v = '0; v.hdr = 32'h1002_001F;
    v.wd[0] = 32'h55; v.wd[1] = 32'h66; v.nwd = 2;
    v.rsp[0] = 32'h1002_0001; v.nrsp = 1;
    v.sel[0] = 16'h001F; v.sel[1] = 16'h0020; v.nsel = 2;
    v.wsel[0] = 16'h001F; v.wdat[0] = 32'h55; v.nwr = 1;
    vecs[4] = v;

    v = '0; v.hdr = 32'h2000_0005;
    v.rsp[0] = 32'h2000_0000; v.nrsp = 1;
    vecs[5] = v;

    v = '0; v.hdr = 32'h2002_0030; v.stall = 20;
    v.rsp[0] = 32'h1111_2222; v.rsp[1] = 32'h3333_4444;
    v.rsp[2] = 32'h2002_0000; v.nrsp = 3;
    v.sel[0] = 16'h0030; v.sel[1] = 16'h0031; v.nsel = 2; v.nrd = 2;
    vecs[6] = v;

    v = '0; v.hdr = 32'h2001_0002;
    v.rsp[0] = 32'h0000_0123; v.rsp[1] = 32'h2001_0000; v.nrsp = 2;
    v.sel[0] = 16'h0002; v.nsel = 1; v.nrd = 1;
    vecs[7] = v;

    v = '0; v.hdr = 32'h2002_FFFF;
    v.rsp[0] = 32'h5A00_00FF; v.rsp[1] = 32'h5A00_0000;
    v.rsp[2] = 32'h2002_0000; v.nrsp = 3;
    v.sel[0] = 16'hFFFF; v.sel[1] = 16'h0000; v.nsel = 2; v.nrd = 2;
    vecs[8] = v;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    mdl_clr = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Reset in the middle of a WRITE burst, waiting for data
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 32'h1003_0008;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
    chk("mid_wdat_ready", 32'(cmd_ready), 32'd1);
    chk("mid_sel", rx_data, 32'h0000_0008);
    #1 reset_n = 1'b0;
    #1 chk_zero("async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    run_txn(9, vecs[7]);

    chk("strobe_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
